// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Brief    : RISC-V execute stage: ALU operation registered into EX/MEM with
//            a valid/ready 2-entry skid buffer and saturating illegal-op count.
//            Optional build macro ALU_EXEC_SLT_EN enables encoding 0111 (SLT).
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control_lines,
    input  logic             ctrl_err,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [4:0]       rd_addr,
    input  logic             reg_write,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_err,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;
`ifdef ALU_EXEC_SLT_EN
    localparam logic [3:0] C_ALU_SLT = 4'b0111;
`endif
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic [4:0]      rd;
        logic            reg_write;
        logic            err;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    entry_t           r_out;
    entry_t           r_skid;
    entry_t           w_entry;
    logic [XLEN-1:0]  w_alu_res;
    logic             w_legal;
    logic             w_err;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_skid_to_out;
    logic [CNT_W-1:0] r_illegal_cnt;

    // ALU datapath and illegal-operation detection on the input side
    always_comb begin
        w_alu_res = '0;
        w_legal   = 1'b1;
        case (alu_control_lines)
            C_ALU_AND: w_alu_res = operand_a & operand_b;
            C_ALU_OR:  w_alu_res = operand_a | operand_b;
            C_ALU_ADD: w_alu_res = operand_a + operand_b;
            C_ALU_SUB: w_alu_res = operand_a - operand_b;
`ifdef ALU_EXEC_SLT_EN
            C_ALU_SLT: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
`endif
            default:   w_legal   = 1'b0;
        endcase
    end

    assign w_err             = ctrl_err | ~w_legal;
    assign w_entry.result    = w_err ? '0 : w_alu_res;
    assign w_entry.zero      = (w_entry.result == '0);
    assign w_entry.rd        = rd_addr;
    assign w_entry.reg_write = reg_write & ~w_err;
    assign w_entry.err       = w_err;

    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_out  = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_out  = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Skid entry is older than anything upstream, so it moves up first
                    if (w_drain) begin
                        w_skid_to_out = 1'b1;
                        w_state_nxt   = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_out) begin
                r_out <= w_entry;
            end else if (w_skid_to_out) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    // Flushed inputs are never accepted, so they do not count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (!flush && w_accept && w_err && (r_illegal_cnt != C_CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + C_CNT_ONE;
        end
    end

    assign out_result    = r_out.result;
    assign out_zero      = r_out.zero;
    assign out_rd        = r_out.rd;
    assign out_reg_write = r_out.reg_write;
    assign out_err       = r_out.err;
    assign illegal_cnt   = r_illegal_cnt;

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the RISC-V core, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control lines and the decoder error flag, together with the operands and destination info from ID/EX.
- Performs the ALU operation and registers the result into the EX/MEM boundary.
- Uses a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept under backpressure.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 16, width of the saturating illegal-operation counter

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush (branch/exception)
- in_valid  input  1  ID/EX entry valid
- in_ready  output  1  stage can accept an entry
- alu_control_lines  input  4  operation select from ALU control decoder
- ctrl_err  input  1  decoder error flag (unsupported funct fields)
- operand_a  input  XLEN  rs1 value
- operand_b  input  XLEN  rs2 value or immediate
- rd_addr  input  5  destination register
- reg_write  input  1  writeback enable
- out_valid  output  1  EX/MEM entry valid
- out_ready  input  1  MEM stage accepts entry
- out_result  output  XLEN  ALU result
- out_zero  output  1  result == 0
- out_rd  output  5  destination register
- out_reg_write  output  1  writeback enable (forced 0 on error)
- out_err  output  1  illegal-operation flag
- illegal_cnt  output  CNT_W  count of accepted illegal operations

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_result=0, out_zero=0, out_rd=0, out_reg_write=0, out_err=0, illegal_cnt=0.
  - Skid entry invalid, so in_ready=1.
- ALU encodings (combinational on input side):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - ADD/SUB wrap modulo 2^XLEN; no overflow flag.
- Illegal operation: any other encoding, or ctrl_err=1.
  - result=0, err=1, reg_write forced 0.
- Zero flag: computed from the XLEN-bit result before registering.
- Latency: accepted entry appears on outputs exactly 1 cycle after acceptance (in_valid & in_ready at edge).
- Handshake:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - in_ready = !skid_valid (registered state only; no combinational path from out_ready).
  - Outputs are held stable while out_valid=1 & out_ready=0.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register full, skid empty.
  - TWO: output register and skid both full.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + drain -> ONE (new data in output register).
  - ONE + accept + no drain -> TWO (new data into skid).
  - ONE + drain only -> EMPTY.
  - TWO + drain -> ONE (skid moves to output register); no accept is possible in TWO.
- Ordering: strictly FIFO; the skid entry always leaves before any newer entry.
- Flush:
  - Highest priority; at the edge, both entries are invalidated (-> EMPTY).
  - An input presented in the same cycle is discarded, and illegal_cnt does not increment for it.
  - A drain coinciding with flush still counts as delivered downstream; the stage state is EMPTY afterwards.
- illegal_cnt:
  - Increments by 1 on each accepted illegal entry.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush; cleared only by reset.
- Reset mid-operation: all entries are lost immediately; outputs go to reset values asynchronously.

Optional Feature:
- Macro: ALU_EXEC_SLT_EN.
- Defined:
  - Encoding 0111 = SLT, signed compare of operand_a < operand_b; result = {XLEN-1 zeros, lt}.
  - Encoding 0111 is treated as a legal operation.
- Undefined: 0111 is illegal (result 0, err=1, counter increments).

Test Plan:
- Reset then ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle out_valid=1, out_result=0x80000000, out_zero=0, out_err=0.
- SUB 5-5, rd=3, reg_write=1 -> out_result=0, out_zero=1, out_rd=3, out_reg_write=1.
- Back-to-back AND 0xF0F0/0x0FF0 then OR 0xF000/0x000F with out_ready=0:
  - After 2 edges, in_ready=0 and out_result=0x00F0 is held.
  - Raise out_ready: 0x00F0 then 0xF00F delivered in order, in_ready returns to 1.
- Encoding 1111, then ADD with ctrl_err=1 -> both give out_err=1, out_reg_write=0, out_result=0; illegal_cnt=2.
- Stage in TWO state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged; later rst_n=0 mid-stream clears outputs immediately.
- SLT with operand_a=0xFFFFFFFF (-1), operand_b=1 -> out_result=1 when ALU_EXEC_SLT_EN is defined; out_err=1 and illegal_cnt+1 otherwise.
